// File: rtl/hwpe_stream_fifo_arbiter_if.sv
// hwpe_stream_fifo_arbiter_if: valid/ready stream bundle used by the FIFO arbiter.
// Signals: valid, ready, data[DATA_WIDTH], strb[DATA_WIDTH/8].
// Modports: master drives valid/data/strb and samples ready; slave is the mirror.
interface hwpe_stream_fifo_arbiter_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    modport master (output valid, data, strb, input ready);
    modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_fifo_arbiter.sv
// hwpe_stream_fifo_arbiter: round-robin burst arbiter merging NB_IN streams into one FIFO push port.
// Ports:
//   clk_i, rst_ni (async active-low), clear_i (sync clear, highest priority)
//   push_i[NB_IN] : requester streams (slave)
//   pop_o         : merged stream towards the FIFO push port (master)
//   grant_o       : one-hot current owner, zero when no owner
//   busy_o        : high while a requester holds the grant
//   beats_o[NB_IN]: per-requester 32-bit handshake counters, only with HWPE_STREAM_FIFO_ARBITER_PERF_EN defined
module hwpe_stream_fifo_arbiter #(
    parameter int NB_IN      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    hwpe_stream_fifo_arbiter_if.slave         push_i [NB_IN],
    hwpe_stream_fifo_arbiter_if.master        pop_o,
    output logic [NB_IN-1:0]                  grant_o,
    output logic                              busy_o
`ifdef HWPE_STREAM_FIFO_ARBITER_PERF_EN
    ,
    output logic [31:0]                       beats_o [NB_IN]
`endif
);
    localparam int IW = $clog2(NB_IN);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                state, state_nxt;
    logic [IW-1:0]         owner, rr_ptr, sel, owner_inc;
    logic [CW-1:0]         beat_cnt;
    logic [IW:0]           scan;
    logic [NB_IN-1:0]      in_valid, in_ready;
    logic [DATA_WIDTH-1:0] in_data [NB_IN];
    logic [SW-1:0]         in_strb [NB_IN];
    logic                  any_valid, own_valid, locked, hs, last_beat, release_own;

    // Interface arrays only accept constant indices, so flatten them into plain arrays.
    for (genvar g = 0; g < NB_IN; g++) begin : g_unpack
        assign in_valid[g]     = push_i[g].valid;
        assign in_data[g]      = push_i[g].data;
        assign in_strb[g]      = push_i[g].strb;
        assign push_i[g].ready = in_ready[g];
    end

    // Round-robin pick: scanning downward and overwriting leaves the first
    // valid index at or above rr_ptr (with wrap) as the winner.
    always_comb begin
        sel       = rr_ptr;
        any_valid = 1'b0;
        scan      = '0;
        for (int i = NB_IN - 1; i >= 0; i--) begin
            scan = {1'b0, rr_ptr} + (IW+1)'(i);
            if (scan >= (IW+1)'(NB_IN)) scan = scan - (IW+1)'(NB_IN);
            if (in_valid[scan[IW-1:0]]) begin
                sel       = scan[IW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign locked      = (state == LOCKED);
    assign own_valid   = in_valid[owner];
    assign owner_inc   = (owner == IW'(NB_IN - 1)) ? '0 : owner + 1'b1;
    assign hs          = pop_o.valid & pop_o.ready;
    assign last_beat   = (beat_cnt == CW'(MAX_BURST - 1));
    // An owner that drops valid gives the grant back even mid-burst.
    assign release_own = locked & (~own_valid | (hs & last_beat));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else if (clear_i) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = locked ? (release_own ? IDLE : LOCKED) : (any_valid ? LOCKED : IDLE);
    end

    // clear_i gates valid and readies so no beat can slip through the aborted burst.
    always_comb begin
        pop_o.valid = 1'b0;
        pop_o.data  = '0;
        pop_o.strb  = '0;
        in_ready    = '0;
        grant_o     = '0;
        if (locked) begin
            grant_o[owner] = 1'b1;
            if (!clear_i) begin
                pop_o.valid     = own_valid;
                pop_o.data      = in_data[owner];
                pop_o.strb      = in_strb[owner];
                in_ready[owner] = pop_o.ready;
            end
        end
    end

    assign busy_o = locked;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else if (clear_i) begin
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else if (!locked) begin
            if (any_valid) begin
                owner    <= sel;
                beat_cnt <= '0;
            end
        end else begin
            if (hs) beat_cnt <= beat_cnt + 1'b1;
            if (release_own) rr_ptr <= owner_inc;
        end
    end

`ifdef HWPE_STREAM_FIFO_ARBITER_PERF_EN
    for (genvar g = 0; g < NB_IN; g++) begin : g_perf
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) beats_o[g] <= '0;
            else if (clear_i) beats_o[g] <= '0;
            else if (hs && owner == IW'(g)) beats_o[g] <= beats_o[g] + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hwpe_stream_fifo_arbiter.sv
// tb_hwpe_stream_fifo_arbiter: randomized self-checking bench for hwpe_stream_fifo_arbiter.
module tb_hwpe_stream_fifo_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, pop_rdy = 1'b0;
    always #5 clk = ~clk;

    hwpe_stream_fifo_arbiter_if #(.DATA_WIDTH(DW)) push [N] ();
    hwpe_stream_fifo_arbiter_if #(.DATA_WIDTH(DW)) pop ();

    logic [N-1:0]    grant, r_ready, v_valid;
    logic            busy;
    logic [DW-1:0]   v_data [N];
    logic [DW/8-1:0] v_strb [N];
`ifdef HWPE_STREAM_FIFO_ARBITER_PERF_EN
    logic [31:0]     beats [N];
`endif

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign push[g].valid = v_valid[g];
        assign push[g].data  = v_data[g];
        assign push[g].strb  = v_strb[g];
        assign r_ready[g]    = push[g].ready;
    end
    assign pop.ready = pop_rdy;

    hwpe_stream_fifo_arbiter #(.NB_IN(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clr),
        .push_i  (push),
        .pop_o   (pop),
        .grant_o (grant),
        .busy_o  (busy)
`ifdef HWPE_STREAM_FIFO_ARBITER_PERF_EN
        ,
        .beats_o (beats)
`endif
    );

    int errors = 0, checks = 0, gap = 0, seq = 0;
    // Reference model: sources are queues of beats, arbitration is tracked as
    // "who owns the grant, how many beats it has moved, where the scan starts".
    logic [DW-1:0]   q [N][$];
    bit              act [N];
    bit              m_lock;
    int              m_own, m_ptr, m_done;
    int unsigned     m_perf [N];
    logic            e_valid, e_busy;
    logic [DW-1:0]   e_data;
    logic [DW/8-1:0] e_strb;
    logic [N-1:0]    e_ready, e_grant;
    // Observation logs taken from the DUT and compared against constants.
    int              bursts[$], cnt;
    logic [N-1:0]    glog[$];
    bit              was_busy;

    task automatic load(input int k, input int n);
        repeat (n) begin
            q[k].push_back({8'(k), 24'(seq)});
            seq++;
        end
    endtask

    task automatic model_clear();
        m_lock = 0; m_own = 0; m_ptr = 0; m_done = 0;
        for (int k = 0; k < N; k++) m_perf[k] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; clr = 1'b0; pop_rdy = 1'b0;
        for (int k = 0; k < N; k++) begin
            q[k].delete(); act[k] = 0; v_valid[k] = 1'b0; v_data[k] = '0; v_strb[k] = '0;
        end
        model_clear();
        bursts.delete(); glog.delete(); cnt = 0; was_busy = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle's inputs at the falling edge and derive expected outputs.
    task automatic cyc(input bit rdy, input bit c);
        @(negedge clk);
        pop_rdy = rdy; clr = c;
        for (int k = 0; k < N; k++) begin
            if (!act[k] && q[k].size() > 0 && $urandom_range(99) >= gap) act[k] = 1;
            v_valid[k] = act[k];
            v_data[k]  = act[k] ? q[k][0] : '0;
            v_strb[k]  = act[k] ? q[k][0][3:0] : '0;
        end
        #1;
        e_busy  = m_lock;
        e_grant = m_lock ? (N'(1) << m_own) : '0;
        e_valid = 1'b0; e_data = '0; e_strb = '0; e_ready = '0;
        if (m_lock && !clr) begin
            e_valid = v_valid[m_own];
            e_data  = v_data[m_own];
            e_strb  = v_strb[m_own];
            e_ready = pop_rdy ? (N'(1) << m_own) : '0;
        end
    endtask

    task automatic track();
        if (busy && !was_busy) glog.push_back(grant);
        if (busy && pop.valid && pop.ready) cnt++;
        if (!busy && was_busy) begin
            bursts.push_back(cnt);
            cnt = 0;
        end
        was_busy = busy;
    endtask

    // Advance the model across the rising edge.
    task automatic adv();
        bit hs;
        int j;
        hs = e_valid && pop_rdy;
        @(posedge clk);
        if (clr) model_clear();
        else if (!m_lock) begin
            for (int i = 0; i < N; i++) begin
                j = (m_ptr + i) % N;
                if (!m_lock && v_valid[j]) begin
                    m_lock = 1; m_own = j; m_done = 0;
                end
            end
        end else begin
            if (hs) begin
                void'(q[m_own].pop_front());
                m_done++;
                m_perf[m_own]++;
                act[m_own] = (q[m_own].size() > 0) && ($urandom_range(99) >= gap);
            end
            if (!v_valid[m_own] || m_done == MB) begin
                m_lock = 0;
                m_ptr = (m_own + 1) % N;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; v_valid = '1; pop_rdy = 1'b1;
        #1;
        checks++;
        if ({pop.valid, pop.data, pop.strb, r_ready, grant, busy} !== '0) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=0", {pop.valid, pop.data, pop.strb, r_ready, grant, busy});
        end
        do_reset();
        for (int c = 0; c < 3; c++) begin
            cyc(1, 0);
            checks++;
            if ({pop.valid, pop.data, pop.strb, r_ready, grant, busy} !== '0) begin
                errors++;
                $display("FAIL reset_idle got=%h exp=0", {pop.valid, pop.data, pop.strb, r_ready, grant, busy});
            end
            adv();
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        gap = 0;
        load(2, 10);
        for (int c = 0; c < 20; c++) begin
            cyc(1, 0);
            checks++;
            if ({pop.valid, pop.data, pop.strb, r_ready, grant, busy} !== {e_valid, e_data, e_strb, e_ready, e_grant, e_busy}) begin
                errors++;
                $display("FAIL single_burst c=%0d got=%h exp=%h", c, {pop.valid, pop.data, pop.strb, r_ready, grant, busy}, {e_valid, e_data, e_strb, e_ready, e_grant, e_busy});
            end
            if (busy && grant !== 4'b0100) begin
                errors++;
                $display("FAIL single_grant c=%0d got=%b exp=0100", c, grant);
            end
            track();
            adv();
        end
        checks++;
        if (bursts.size() != 3 || bursts[0] != 4 || bursts[1] != 4 || bursts[2] != 2) begin
            errors++;
            $display("FAIL single_bursts got=%p exp='{4,4,2}", bursts);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        gap = 0;
        for (int k = 0; k < N; k++) load(k, 8);
        for (int c = 0; c < 30; c++) begin
            cyc(1, 0);
            checks++;
            if ({pop.valid, pop.data, pop.strb, r_ready, grant, busy} !== {e_valid, e_data, e_strb, e_ready, e_grant, e_busy}) begin
                errors++;
                $display("FAIL round_robin c=%0d got=%h exp=%h", c, {pop.valid, pop.data, pop.strb, r_ready, grant, busy}, {e_valid, e_data, e_strb, e_ready, e_grant, e_busy});
            end
            track();
            adv();
        end
        checks++;
        if (glog.size() < 5 || glog[0] !== 4'b0001 || glog[1] !== 4'b0010 || glog[2] !== 4'b0100 || glog[3] !== 4'b1000 || glog[4] !== 4'b0001) begin
            errors++;
            $display("FAIL rr_order got=%p exp=1,2,4,8,1", glog);
        end
        checks++;
        if (bursts.size() < 4 || bursts[0] != MB || bursts[1] != MB || bursts[2] != MB || bursts[3] != MB) begin
            errors++;
            $display("FAIL rr_burst_len got=%p exp=4 each", bursts);
        end
    endtask

    task automatic test_drop_valid();
        do_reset();
        gap = 0;
        load(1, 3);
        for (int c = 0; c < 20; c++) begin
            if (c == 1) begin
                load(0, 2);
                load(3, 2);
            end
            cyc(1, 0);
            checks++;
            if ({pop.valid, pop.data, pop.strb, r_ready, grant, busy} !== {e_valid, e_data, e_strb, e_ready, e_grant, e_busy}) begin
                errors++;
                $display("FAIL drop_valid c=%0d got=%h exp=%h", c, {pop.valid, pop.data, pop.strb, r_ready, grant, busy}, {e_valid, e_data, e_strb, e_ready, e_grant, e_busy});
            end
            track();
            adv();
        end
        checks++;
        if (glog.size() < 3 || glog[0] !== 4'b0010 || glog[1] !== 4'b1000 || glog[2] !== 4'b0001 || bursts[0] != 3) begin
            errors++;
            $display("FAIL drop_order got=%p bursts=%p exp=2,8,1 first burst 3", glog, bursts);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] d0;
        do_reset();
        gap = 0;
        load(0, 4);
        d0 = q[0][0];
        for (int c = 0; c < 16; c++) begin
            cyc(!(c >= 1 && c <= 5), 0);
            checks++;
            if ({pop.valid, pop.data, pop.strb, r_ready, grant, busy} !== {e_valid, e_data, e_strb, e_ready, e_grant, e_busy}) begin
                errors++;
                $display("FAIL stall c=%0d got=%h exp=%h", c, {pop.valid, pop.data, pop.strb, r_ready, grant, busy}, {e_valid, e_data, e_strb, e_ready, e_grant, e_busy});
            end
            if (c >= 1 && c <= 5 && {pop.valid, pop.data, r_ready, grant} !== {1'b1, d0, 4'b0000, 4'b0001}) begin
                errors++;
                $display("FAIL stall_hold c=%0d got=%h exp=%h", c, {pop.valid, pop.data, r_ready, grant}, {1'b1, d0, 4'b0000, 4'b0001});
            end
            track();
            adv();
        end
        checks++;
        if (bursts.size() != 1 || bursts[0] != 4) begin
            errors++;
            $display("FAIL stall_beats got=%p exp='{4}", bursts);
        end
    endtask

    task automatic test_clear();
        do_reset();
        gap = 0;
        load(1, 1);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                load(2, 4);
                load(0, 4);
            end
            cyc(1, c == 5);
            checks++;
            if ({pop.valid, pop.data, pop.strb, r_ready, grant, busy} !== {e_valid, e_data, e_strb, e_ready, e_grant, e_busy}) begin
                errors++;
                $display("FAIL clear c=%0d got=%h exp=%h", c, {pop.valid, pop.data, pop.strb, r_ready, grant, busy}, {e_valid, e_data, e_strb, e_ready, e_grant, e_busy});
            end
            if (c == 5 && {pop.valid, r_ready, grant} !== {1'b0, 4'b0000, 4'b0100}) begin
                errors++;
                $display("FAIL clear_cycle got=%h exp=%h", {pop.valid, r_ready, grant}, {1'b0, 4'b0000, 4'b0100});
            end
            if (c == 6 && {grant, busy} !== 5'b0) begin
                errors++;
                $display("FAIL clear_idle got=%b exp=0", {grant, busy});
            end
`ifdef HWPE_STREAM_FIFO_ARBITER_PERF_EN
            if (c == 6 && {beats[0], beats[1], beats[2], beats[3]} !== '0) begin
                errors++;
                $display("FAIL clear_perf got=%h exp=0", {beats[0], beats[1], beats[2], beats[3]});
            end
`endif
            if (c == 7 && grant !== 4'b0001) begin
                errors++;
                $display("FAIL clear_rrptr got=%b exp=0001", grant);
            end
            adv();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        gap = 0;
        load(2, 6);
        for (int c = 0; c < 3; c++) begin
            cyc(1, 0);
            adv();
        end
        cyc(1, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pop.valid, pop.data, pop.strb, r_ready, grant, busy} !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", {pop.valid, pop.data, pop.strb, r_ready, grant, busy});
        end
        do_reset();
    endtask

    task automatic test_perf();
        do_reset();
        gap = 0;
        load(3, 7);
        load(0, 5);
        for (int c = 0; c < 30; c++) begin
            cyc(1, 0);
            checks++;
            if ({pop.valid, pop.data, pop.strb, r_ready, grant, busy} !== {e_valid, e_data, e_strb, e_ready, e_grant, e_busy}) begin
                errors++;
                $display("FAIL perf_run c=%0d got=%h exp=%h", c, {pop.valid, pop.data, pop.strb, r_ready, grant, busy}, {e_valid, e_data, e_strb, e_ready, e_grant, e_busy});
            end
            adv();
        end
`ifdef HWPE_STREAM_FIFO_ARBITER_PERF_EN
        checks++;
        if (beats[0] !== 32'd5 || beats[1] !== 32'd0 || beats[2] !== 32'd0 || beats[3] !== 32'd7) begin
            errors++;
            $display("FAIL perf_counts got=%0d,%0d,%0d,%0d exp=5,0,0,7", beats[0], beats[1], beats[2], beats[3]);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        gap = 30;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) load($urandom_range(N - 1), $urandom_range(1, 6));
            cyc($urandom_range(3) != 0, $urandom_range(59) == 0);
            checks++;
            if ({pop.valid, pop.data, pop.strb, r_ready, grant, busy} !== {e_valid, e_data, e_strb, e_ready, e_grant, e_busy}) begin
                errors++;
                $display("FAIL random c=%0d got=%h exp=%h", c, {pop.valid, pop.data, pop.strb, r_ready, grant, busy}, {e_valid, e_data, e_strb, e_ready, e_grant, e_busy});
            end
            adv();
        end
`ifdef HWPE_STREAM_FIFO_ARBITER_PERF_EN
        for (int k = 0; k < N; k++) begin
            checks++;
            if (beats[k] !== 32'(m_perf[k])) begin
                errors++;
                $display("FAIL random_perf k=%0d got=%0d exp=%0d", k, beats[k], m_perf[k]);
            end
        end
`endif
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_drop_valid();
        test_stall();
        test_clear();
        test_async_reset();
        test_perf();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
